// File: rtl/wb_stage.sv
// Write-back stage: takes one instruction from MEM and waits for load data when needed.
// It drives a single register-file write per retired instruction and counts the retired instructions.
module wb_stage (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [4:0]  mem_rd,
    input  logic        mem_regwrite,
    input  logic [1:0]  mem_wbsel,
    input  logic [31:0] mem_alu_result,
    input  logic [31:0] mem_pc_plus4,
    input  logic [1:0]  mem_load_size,
    input  logic        mem_load_unsigned,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    input  logic        flush,
    output logic        RegWrite,
    output logic [4:0]  WriteRegister,
    output logic [31:0] WriteData,
    output logic        wb_stall,
    output logic [31:0] instret
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LOAD = 2'd1,
        WRITE     = 2'd2
    } state_t;

    localparam logic [1:0] WB_LOAD   = 2'b01;
    localparam logic [1:0] WB_LINK   = 2'b10;
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;

    state_t      state;
    state_t      state_next;
    logic        accept;
    logic        load_done;
    logic        in_write;

    logic [4:0]  rd_q;
    logic        regwrite_q;
    logic [1:0]  wbsel_q;
    logic [31:0] alu_q;
    logic [31:0] pc4_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [31:0] load_data_q;

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_ext;
    logic [31:0] instret_q;
    logic [31:0] instret_next;

    assign mem_ready = (state != WAIT_LOAD);
    assign wb_stall  = (state == WAIT_LOAD);
    assign in_write  = (state == WRITE);
    assign accept    = mem_valid && mem_ready;
    // flush beats a same-cycle data return, so a killed load never captures data
    assign load_done = (state == WAIT_LOAD) && dmem_rvalid && !flush;

    always_comb begin
        state_next = state;
        case (state)
            IDLE, WRITE: begin
                if (accept) begin
                    state_next = (mem_wbsel == WB_LOAD) ? WAIT_LOAD : WRITE;
                end else begin
                    state_next = IDLE;
                end
            end
            WAIT_LOAD: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (dmem_rvalid) begin
                    state_next = WRITE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Lane select uses the byte offset captured with the instruction, not the live MEM inputs
    always_comb begin
        byte_lane = dmem_rdata[7:0];
        case (alu_q[1:0])
            2'd0:    byte_lane = dmem_rdata[7:0];
            2'd1:    byte_lane = dmem_rdata[15:8];
            2'd2:    byte_lane = dmem_rdata[23:16];
            default: byte_lane = dmem_rdata[31:24];
        endcase
        half_lane = alu_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (size_q)
            SIZE_BYTE: load_ext = {{24{~unsigned_q & byte_lane[7]}}, byte_lane};
            SIZE_HALF: load_ext = {{16{~unsigned_q & half_lane[15]}}, half_lane};
            default:   load_ext = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_q        <= 5'd0;
            regwrite_q  <= 1'b0;
            wbsel_q     <= 2'b00;
            alu_q       <= 32'd0;
            pc4_q       <= 32'd0;
            size_q      <= 2'b00;
            unsigned_q  <= 1'b0;
            load_data_q <= 32'd0;
        end else begin
            if (accept) begin
                rd_q       <= mem_rd;
                regwrite_q <= mem_regwrite;
                wbsel_q    <= mem_wbsel;
                alu_q      <= mem_alu_result;
                pc4_q      <= mem_pc_plus4;
                size_q     <= mem_load_size;
                unsigned_q <= mem_load_unsigned;
            end
            if (load_done) begin
                load_data_q <= load_ext;
            end
        end
    end

    always_comb begin
        instret_next = instret_q + {31'd0, in_write};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            instret_q <= 32'd0;
        end else begin
            instret_q <= instret_next;
        end
    end

    assign instret = instret_q;

    always_comb begin
        RegWrite      = 1'b0;
        WriteRegister = 5'd0;
        WriteData     = 32'd0;
        if (in_write) begin
            RegWrite      = regwrite_q && (rd_q != 5'd0);
            WriteRegister = rd_q;
            case (wbsel_q)
                WB_LOAD: WriteData = load_data_q;
                WB_LINK: WriteData = pc4_q;
                default: WriteData = alu_q;
            endcase
        end
    end

endmodule
